pipe_adder: RTL
===============

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, meaning pipeline depth and number of carry-chain chunks; WIDTH % STAGES == 0 is required.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port in_valid  input  1  operand set presented.
REQ-006 Port in_ready  output  1  block accepts operands this cycle.
REQ-007 Port a  input  WIDTH  operand A.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port op  input  2  operation: 00 ADD, 01 SUB, 10 ADC, 11 SBB.
REQ-010 Port cin  input  1  carry-in; used by ADC/SBB only.
REQ-011 Port out_valid  output  1  result and flags valid.
REQ-012 Port out_ready  input  1  downstream consumes result this cycle.
REQ-013 Port sum  output  WIDTH  result.
REQ-014 Port flags  output  4  {N, Z, C, V}.

Function
REQ-015 Transfers SHALL occur on a rising edge with valid && ready; the input side SHALL NOT depend on in_valid for in_ready.
REQ-016 Effective B and carry-in SHALL be: ADD b,0; SUB ~b,1; ADC b,cin; SBB ~b,cin.
REQ-017 Stage k (0..STAGES-1) SHALL add bits [k*W/S +: W/S] using the carry registered from stage k-1; higher operand chunks travel unmodified alongside.
REQ-018 Each stage SHALL hold one valid bit; stage k advances when it is empty or stage k+1 (or the output, for the last stage) advances in the same cycle.
REQ-019 in_ready SHALL equal "stage 0 empty or stage 0 advances this cycle".
REQ-020 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no stall; throughput one result per cycle while out_ready=1.
REQ-021 Results SHALL leave in acceptance order; no drop, duplication or reordering under any out_ready pattern.
REQ-022 While out_valid=1 and out_ready=0, sum and flags SHALL hold stable.
REQ-023 C SHALL be the carry out of bit WIDTH-1 (SUB: C=1 means no borrow).
REQ-024 V SHALL be set when the two effective operands' MSBs are equal and differ from sum's MSB.
REQ-025 N SHALL equal sum[WIDTH-1]; Z SHALL be 1 only when all sum bits are 0, accumulated as a per-chunk zero bit carried through stages.
REQ-026 Arithmetic SHALL wrap modulo 2^WIDTH; no saturation.
REQ-027 STAGES=1 SHALL yield a single registered adder with latency 1.
REQ-028 With all stages full and out_ready=0, in_ready SHALL be 0 the same cycle; raising out_ready SHALL reassert in_ready combinationally.

Reset
REQ-029 rst_n low SHALL asynchronously clear all stage valid bits, giving out_valid=0, in_ready=1 (after release), sum=0, flags=0.
REQ-030 Reset mid-operation SHALL discard all in-flight operations; first result after release comes only from operands accepted after release.
REQ-031 Datapath registers other than valid bits MAY be reset to 0; outputs SHALL be 0 while rst_n low.

Structure
REQ-032 Op encodings (ADD/SUB/ADC/SBB) and flag bit indices (N=3, Z=2, C=1, V=0) SHALL live in a shared package.
REQ-033 One sub-module pipe_adder_stage SHALL implement a chunk adder plus its valid/advance register, instantiated STAGES times by generate.
REQ-034 Target size 120-400 RTL lines; no multi-cycle paths.

Verification (WIDTH=32, STAGES=4)
REQ-035 ADD 0xFFFFFFFF+0x00000001, out_ready=1 -> 4 cycles later sum=0x00000000, N0 Z1 C1 V0.
REQ-036 SUB 0x80000000-0x00000001 -> sum=0x7FFFFFFF, N0 Z0 C1 V1.
REQ-037 ADC 0x7FFFFFFF+0x00000000, cin=1 -> sum=0x80000000, N1 Z0 C0 V1; SBB 5-3, cin=0 -> sum=0x00000001, C1.
REQ-038 8 back-to-back random ops, out_ready=1 -> 8 consecutive out_valid cycles, results match model, in order.
REQ-039 Continuous input, out_ready=0 for 6 cycles -> exactly 4 accepted then in_ready=0, head result stable; out_ready=1 -> drains in order, no loss.
REQ-040 rst_n pulsed low with 3 ops in flight -> out_valid=0 immediately; none of the 3 ever appears.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared op encodings and flag bit positions for pipe_adder.
package pipe_adder_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBB = 2'b11
    } op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/pipe_adder_stage.sv
// pipe_adder_stage: adds chunk K of the operands using the carry from the previous stage,
// and registers the running result alongside a single valid bit.
module pipe_adder_stage #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int K      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic             carry_i,
    input  logic             zero_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] s_o,
    output logic             carry_o,
    output logic             zero_o
);
    localparam int CW = WIDTH / STAGES;

    logic [CW:0]      chunk_d;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             valid_q, carry_q, zero_q;

    assign chunk_d = {1'b0, a_i[K*CW +: CW]} + {1'b0, b_i[K*CW +: CW]} + {{CW{1'b0}}, carry_i};

    always_comb begin
        s_d = s_i;
        s_d[K*CW +: CW] = chunk_d[CW-1:0];
    end

    // Datapath only loads with a real operand so idle stages keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (adv_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                a_q     <= a_i;
                b_q     <= b_i;
                s_q     <= s_d;
                carry_q <= chunk_d[CW];
                zero_q  <= zero_i && (chunk_d[CW-1:0] == '0);
            end
        end
    end

    assign valid_o = valid_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign s_o     = s_q;
    assign carry_o = carry_q;
    assign zero_o  = zero_q;

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: valid/ready pipelined ADD/SUB/ADC/SBB, one carry-chain chunk per stage,
// flags {N,Z,C,V} taken from the last stage.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [3:0]       flags
);
    logic [WIDTH-1:0] a_w [STAGES+1];
    logic [WIDTH-1:0] b_w [STAGES+1];
    logic [WIDTH-1:0] s_w [STAGES+1];
    logic [STAGES:0]  v_w, c_w, z_w;
    logic [STAGES:0]  adv_w;
    op_e              op_w;

    assign op_w   = op_e'(op);
    assign v_w[0] = in_valid;
    assign a_w[0] = a;
    assign b_w[0] = (op_w == OP_SUB || op_w == OP_SBB) ? ~b : b;
    assign c_w[0] = (op_w == OP_ADD) ? 1'b0 : (op_w == OP_SUB) ? 1'b1 : cin;
    assign s_w[0] = '0;
    assign z_w[0] = 1'b1;

    // Stage k advances when it is empty or the stage after it advances.
    always_comb begin
        adv_w = '0;
        adv_w[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--)
            adv_w[i] = !v_w[i+1] || adv_w[i+1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_adder_stage #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .K      (k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv_i   (adv_w[k]),
            .valid_i (v_w[k]),
            .a_i     (a_w[k]),
            .b_i     (b_w[k]),
            .s_i     (s_w[k]),
            .carry_i (c_w[k]),
            .zero_i  (z_w[k]),
            .valid_o (v_w[k+1]),
            .a_o     (a_w[k+1]),
            .b_o     (b_w[k+1]),
            .s_o     (s_w[k+1]),
            .carry_o (c_w[k+1]),
            .zero_o  (z_w[k+1])
        );
    end

    assign in_ready  = adv_w[0];
    assign out_valid = v_w[STAGES];
    assign sum       = s_w[STAGES];

    always_comb begin
        flags = '0;
        flags[FLAG_N] = s_w[STAGES][WIDTH-1];
        flags[FLAG_Z] = z_w[STAGES];
        flags[FLAG_C] = c_w[STAGES];
        flags[FLAG_V] = (a_w[STAGES][WIDTH-1] == b_w[STAGES][WIDTH-1]) &&
                        (s_w[STAGES][WIDTH-1] != a_w[STAGES][WIDTH-1]);
    end

endmodule
